ika2151_core: RTL and testbench
===============================

// Module: ika2151_core
// PURPOSE
//  Timing front-end of the IKA2151 (YM2151/OPM-compatible FM synth), clocked by a fast emulation clock.
//  - Qualifies the master clock phiM with a clock enable.
//  - Derives the chip phase clock phi1 (phiM/2).
//  - Runs the 32-slot operator cycle counter.
//  - Generates the DAC sample-hold strobes SH1/SH2 (one pair per sample = 64 phiM).
//  Sits at the top of the OPM; later register/operator blocks consume its phi1 enables and slot count.
// PARAMETERS
//  (none) fixed-function; slot count 32, SH pulse width 8 slots are localparams in the package.
// PORTS
//  i_EMUCLK       in   1  single system clock; every flop is on its rising edge
//  i_IC_n         in   1  initial-clear; reset is asynchronous and active-low
//  i_phiM_PCEN_n  in   1  active-low phiM enable; low for one i_EMUCLK cycle per phiM period (1 of 4 in system use)
//  o_phi1         out  1  phi1 clock level = phiM/2
//  o_SH1          out  1  left DAC sample-hold strobe, active high
//  o_SH2          out  1  right DAC sample-hold strobe, active high
// BEHAVIOUR
//  Reset
//  - i_IC_n low asynchronously clears all state: o_phi1=0, o_SH1=0, o_SH2=0, slot counter=0, sync regs=0.
//  - Release is synchronized: a 2-flop chain clocked only on phiM enables gives ic_sync.
//  - All logic below stays held in reset until ic_sync=1, i.e. 2 phiM enables after the i_IC_n rise.
//  - A mid-operation i_IC_n low returns every output to its reset value within the same i_EMUCLK cycle (async).
//  phiM tick
//  - Defined as: posedge i_EMUCLK with i_phiM_PCEN_n==0. Nothing changes on other edges.
//  - If i_phiM_PCEN_n is held low continuously, every i_EMUCLK edge is a tick.
//  phi1 and phase enables
//  - On each tick: phi1 <= ~phi1.
//  - phi1_pcen (internal) = tick & phi1==0, i.e. phi1 about to rise.
//  - phi1_ncen (internal) = tick & phi1==1.
//  Slot counter
//  - 5-bit counter, increments by 1 on each phi1_ncen.
//  - Wraps 31->0; one full wrap = 64 phiM ticks = one sample.
//  SH strobes
//  - Registered; updated on phi1_ncen from the next counter value.
//  - o_SH1 = 1 while slot in 0..7; o_SH2 = 1 while slot in 16..23; otherwise 0.
//  - Each is high 16 phiM ticks per 64 and never overlaps the other.
//  - After reset release the first SH1 pulse covers slots 1..7 only (counter leaves 0 on the first phi1_ncen).
//    SH2 is a full 8-slot pulse from the first one on.
//  Throughput
//  - No handshake; free-running. Latency from tick to output change = 1 i_EMUCLK cycle.
// STRUCTURE
//  Package ika2151_pkg:
//  - localparams SLOT_CNT=32, SH1_START=0, SH2_START=16, SH_LEN=8.
//  - typedef slot_t (5-bit).
//  Sub-module ika2151_timing_gen holds:
//  - the reset synchronizer
//  - the phi1 divider
//  - the slot counter
//  - the SH decode
//  Top ika2151_core instantiates it and exposes the phi1 enables for future operator stages.
// TESTING
//  1 Reset: IC_n low 100 EMUCLK with enable 1-in-4 -> o_phi1=o_SH1=o_SH2=0 throughout; also async drop mid-run clears outputs immediately.
//  2 Release: IC_n high -> first o_phi1 toggle on the 3rd enable pulse after release.
//     From then: o_phi1 period = 8 EMUCLK, 50% duty.
//  3 Sample rate: after release, SH1 rising edges are 256 EMUCLK apart (64 phiM); SH2 rises exactly 128 EMUCLK after SH1.
//  4 Pulse width: each of o_SH1/o_SH2 high 64 EMUCLK (16 phiM); never both high.
//  5 Enable gating: hold i_phiM_PCEN_n high 40 EMUCLK -> all outputs frozen, then resume with no skipped slot.
//  6 Enable stuck low: phi1 toggles every EMUCLK; SH period = 64 EMUCLK.

Source files
------------

// File: rtl/ika2151_pkg.sv
// Shared constants and types for the IKA2151 timing front-end.
package ika2151_pkg;

  localparam int SLOT_CNT  = 32;
  localparam int SH1_START = 0;
  localparam int SH2_START = 16;
  localparam int SH_LEN    = 8;

  typedef logic [4:0] slot_t;

  // True when slot s lies inside the SH window [start, start+SH_LEN).
  function automatic logic in_sh_window(input slot_t s, input int start);
    return (int'(s) >= start) && (int'(s) < start + SH_LEN);
  endfunction

endpackage

// File: rtl/ika2151_timing_gen.sv
// Reset synchronizer, phi1 divider, 32-slot counter and SH1/SH2 decode.
module ika2151_timing_gen
  import ika2151_pkg::*;
(
  input  logic i_EMUCLK,
  input  logic i_IC_n,
  input  logic i_phiM_PCEN_n,
  output logic o_phi1,
  output logic o_phi1_pcen,
  output logic o_phi1_ncen,
  output logic o_SH1,
  output logic o_SH2
);

  logic [1:0] ic_pipe;
  logic       ic_sync;
  logic       tick;
  slot_t      slot;
  slot_t      slot_nxt;

  assign tick        = ~i_phiM_PCEN_n;
  assign ic_sync     = ic_pipe[1];
  // Enables are gated by ic_sync, which keeps everything parked at its
  // cleared value until the synchronized release arrives.
  assign o_phi1_pcen = tick & ic_sync & ~o_phi1;
  assign o_phi1_ncen = tick & ic_sync &  o_phi1;
  assign slot_nxt    = (slot == slot_t'(SLOT_CNT - 1)) ? '0 : slot + 5'd1;

  // Release synchronizer: only advances on phiM ticks so ic_sync rises on the 2nd tick.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n)   ic_pipe <= '0;
    else if (tick) ic_pipe <= {ic_pipe[0], 1'b1};
  end

  // phi1 divider, slot counter and registered SH strobes (decoded from the next slot).
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      o_phi1 <= 1'b0;
      slot   <= '0;
      o_SH1  <= 1'b0;
      o_SH2  <= 1'b0;
    end else begin
      if (tick && ic_sync) o_phi1 <= ~o_phi1;
      if (o_phi1_ncen) begin
        slot  <= slot_nxt;
        o_SH1 <= in_sh_window(slot_nxt, SH1_START);
        o_SH2 <= in_sh_window(slot_nxt, SH2_START);
      end
    end
  end

endmodule

// File: rtl/ika2151_core.sv
// IKA2151 timing front-end top: phi1 clock, phase enables and DAC SH strobes.
module ika2151_core
  import ika2151_pkg::*;
(
  input  logic i_EMUCLK,
  input  logic i_IC_n,
  input  logic i_phiM_PCEN_n,
  output logic o_phi1,
  output logic o_phi1_PCEN,
  output logic o_phi1_NCEN,
  output logic o_SH1,
  output logic o_SH2
);

  // phi1 enables go out so later operator stages can share this timebase.
  ika2151_timing_gen u_timing (
    .i_EMUCLK      (i_EMUCLK),
    .i_IC_n        (i_IC_n),
    .i_phiM_PCEN_n (i_phiM_PCEN_n),
    .o_phi1        (o_phi1),
    .o_phi1_pcen   (o_phi1_PCEN),
    .o_phi1_ncen   (o_phi1_NCEN),
    .o_SH1         (o_SH1),
    .o_SH2         (o_SH2)
  );

endmodule

// File: tb/tb_ika2151_core.sv
// Randomized bench for ika2151_core against a tick-count reference model.
module tb_ika2151_core;

  logic EMUCLK = 1'b0;
  logic IC_n   = 1'b1;
  logic PCEN_n = 1'b1;
  logic phi1, pcen, ncen, sh1, sh2;

  ika2151_core dut (
    .i_EMUCLK      (EMUCLK),
    .i_IC_n        (IC_n),
    .i_phiM_PCEN_n (PCEN_n),
    .o_phi1        (phi1),
    .o_phi1_PCEN   (pcen),
    .o_phi1_NCEN   (ncen),
    .o_SH1         (sh1),
    .o_SH2         (sh2)
  );

  always #5 EMUCLK = ~EMUCLK;

  int total = 0;
  int bad   = 0;
  int k     = 0;   // phiM ticks seen since the last IC_n release
  int cyc   = 0;
  logic mon  = 1'b0;
  logic meas = 1'b0;
  logic [2:0] r;
  logic p_phi = 1'b0, p1 = 1'b0, p2 = 1'b0;
  int w1 = 0, w2 = 0;
  int sh1_r[$], sh2_r[$], phi_r[$], sh1_w[$], sh2_w[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Outputs as a function of tick count: the first two ticks only sync the
  // release, then phi1 toggles per tick and the slot advances every 2 ticks.
  function automatic logic [2:0] ref_out(input int kk);
    int e, ns, s;
    e  = (kk > 2) ? kk - 2 : 0;
    ns = e / 2;
    s  = ns % 32;
    return {1'(e % 2), (ns >= 1) && (s < 8), (s >= 16) && (s < 24)};
  endfunction

  always @(posedge EMUCLK or negedge IC_n) begin
    if (!IC_n)        k = 0;
    else if (!PCEN_n) k++;
  end

  always @(posedge EMUCLK) cyc++;

  always @(negedge EMUCLK) begin
    if (mon) begin
      r = ref_out(k);
      chk("phi1", phi1, r[2]);
      chk("sh1", sh1, r[1]);
      chk("sh2", sh2, r[0]);
      chk("sh_overlap", sh1 & sh2, 0);
      chk("pcen", pcen, !PCEN_n && IC_n && k >= 2 && !r[2]);
      chk("ncen", ncen, !PCEN_n && IC_n && k >= 2 &&  r[2]);
    end
    if (meas && phi1 && !p_phi) phi_r.push_back(cyc);
    if (meas && sh1 && !p1) sh1_r.push_back(cyc);
    if (meas && sh2 && !p2) sh2_r.push_back(cyc);
    if (sh1) w1++; else if (p1) begin if (meas) sh1_w.push_back(w1); w1 = 0; end
    if (sh2) w2++; else if (p2) begin if (meas) sh2_w.push_back(w2); w2 = 0; end
    p_phi = phi1; p1 = sh1; p2 = sh2;
  end

  // mode 0: enable 1-in-4, 1: stuck low, 2: held high, 3: random
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge EMUCLK); #1;
      case (mode)
        0:       PCEN_n = (i % 4) != 3;
        1:       PCEN_n = 1'b0;
        2:       PCEN_n = 1'b1;
        default: PCEN_n = $urandom_range(0, 2) != 0;
      endcase
    end
  endtask

  task automatic set_ic(input logic v);
    @(posedge EMUCLK); #1;
    IC_n = v;
  endtask

  task automatic period_check(input string tag, input int per, input int phiper);
    int found;
    chk({tag, "_sh1_rises"}, sh1_r.size() >= 2, 1);
    chk({tag, "_sh2_rises"}, sh2_r.size() >= 1, 1);
    for (int i = 1; i < sh1_r.size(); i++) chk({tag, "_sh1_period"}, sh1_r[i] - sh1_r[i-1], per);
    for (int i = 1; i < phi_r.size(); i++) chk({tag, "_phi1_period"}, phi_r[i] - phi_r[i-1], phiper);
    foreach (sh1_w[i]) chk({tag, "_sh1_width"}, sh1_w[i], per / 4);
    foreach (sh2_w[i]) chk({tag, "_sh2_width"}, sh2_w[i], per / 4);
    foreach (sh2_r[i]) begin
      found = 0;
      foreach (sh1_r[j]) if (sh2_r[i] - sh1_r[j] == per / 2) found = 1;
      if (sh2_r[i] - per / 2 > sh1_r[0]) chk({tag, "_sh2_offset"}, found, 1);
    end
    sh1_r.delete(); sh2_r.delete(); phi_r.delete(); sh1_w.delete(); sh2_w.delete();
  endtask

  initial begin
    #1 IC_n = 1'b0;
    #1 mon = 1'b1;
    // held in reset with normal enable cadence
    run(100, 0);
    // release, settle, then measure the 1-in-4 timebase
    set_ic(1'b1);
    run(300, 0);
    meas = 1'b1;
    run(1100, 0);
    meas = 1'b0;
    period_check("en4", 256, 8);
    // asynchronous clear in the middle of operation
    set_ic(1'b0);
    #1;
    chk("async_phi1", phi1, 0);
    chk("async_sh1", sh1, 0);
    chk("async_sh2", sh2, 0);
    run(20, 0);
    // random enables, a long freeze, then regular cadence again
    set_ic(1'b1);
    run(200, 3);
    run(40, 2);
    run(600, 0);
    // enable stuck low: every EMUCLK edge is a tick
    set_ic(1'b0);
    run(10, 1);
    set_ic(1'b1);
    run(300, 1);
    meas = 1'b1;
    run(300, 1);
    meas = 1'b0;
    period_check("stuck", 64, 2);
    // long random run with occasional freezes
    for (int b = 0; b < 6; b++) begin
      run(250, 3);
      run($urandom_range(5, 40), 2);
    end
    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
